// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-SRC control sequencer: opcode values,
// ALU operation codes, the sequencer state enum, instruction classes and
// the packed control word that carries every datapath control.
package cpu_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU select codes; 0 is the idle value driven whenever no ALU op is needed.
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHRA = 4'd6;
  localparam logic [3:0] ALU_SHL  = 4'd7;
  localparam logic [3:0] ALU_ROR  = 4'd8;
  localparam logic [3:0] ALU_ROL  = 4'd9;
  localparam logic [3:0] ALU_NEG  = 4'd10;
  localparam logic [3:0] ALU_NOT  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam logic [3:0] ALU_DIV  = 4'd13;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_UNARY, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_BR, CL_JR,
    CL_JAL, CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_MULDIV, CL_NOP, CL_HALT
  } iclass_t;

  typedef struct packed {
    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout;
    logic MARin, MDRin, IRin, Yin, PCin, Zlowin, Zhighin, HIin, LOin, outPortEnable;
    logic Gra, Grb, Grc, Rin, Rout, BAout, conInput;
    logic IncPC, Read, wren;
    logic [3:0] ctrl;
  } ctrl_word_t;

  // Maps an opcode to the ALU operation it requests; immediates share
  // the code of their register form.
  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: alu_code = ALU_ADD;
      OP_SUB:          alu_code = ALU_SUB;
      OP_AND, OP_ANDI: alu_code = ALU_AND;
      OP_OR, OP_ORI:   alu_code = ALU_OR;
      OP_SHR:          alu_code = ALU_SHR;
      OP_SHRA:         alu_code = ALU_SHRA;
      OP_SHL:          alu_code = ALU_SHL;
      OP_ROR:          alu_code = ALU_ROR;
      OP_ROL:          alu_code = ALU_ROL;
      OP_NEG:          alu_code = ALU_NEG;
      OP_NOT:          alu_code = ALU_NOT;
      OP_MUL:          alu_code = ALU_MUL;
      OP_DIV:          alu_code = ALU_DIV;
      default:         alu_code = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// instruction/condition inputs to the sequencer and every control strobe back.
interface control_sequencer_if #(parameter int CTRLW = 4);
  logic [31:0] IR;
  logic CON, Stop;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout;
  logic MARin, MDRin, IRin, Yin, PCin, Zlowin, Zhighin, HIin, LOin, outPortEnable;
  logic Gra, Grb, Grc, Rin, Rout, BAout, conInput;
  logic IncPC, Read, wren;
  logic [CTRLW-1:0] ctrl;
  logic Run;

  modport master (
    input  IR, CON, Stop,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
           MARin, MDRin, IRin, Yin, PCin, Zlowin, Zhighin, HIin, LOin, outPortEnable,
           Gra, Grb, Grc, Rin, Rout, BAout, conInput, IncPC, Read, wren, ctrl, Run
  );

  modport slave (
    output IR, CON, Stop,
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout,
           MARin, MDRin, IRin, Yin, PCin, Zlowin, Zhighin, HIin, LOin, outPortEnable,
           Gra, Grb, Grc, Rin, Rout, BAout, conInput, IncPC, Read, wren, ctrl, Run
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// opcode_decode: combinational opcode -> instruction-class decoder.
// Configuration macro CS_MULDIV_EN: when undefined, mul/div decode as nop.
import cpu_pkg::*;

module opcode_decode (
  input  logic [4:0] opcode,
  output iclass_t    iclass
);

  // Classify the opcode; reserved opcodes fall through to nop.
  always_comb begin
    iclass = CL_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
        iclass = CL_ALU;
      OP_NEG, OP_NOT:           iclass = CL_UNARY;
      OP_ADDI, OP_ANDI, OP_ORI: iclass = CL_IMM;
      OP_LD:                    iclass = CL_LD;
      OP_LDI:                   iclass = CL_LDI;
      OP_ST:                    iclass = CL_ST;
      OP_BR:                    iclass = CL_BR;
      OP_JR:                    iclass = CL_JR;
      OP_JAL:                   iclass = CL_JAL;
      OP_MFHI:                  iclass = CL_MFHI;
      OP_MFLO:                  iclass = CL_MFLO;
      OP_IN:                    iclass = CL_IN;
      OP_OUT:                   iclass = CL_OUT;
`ifdef CS_MULDIV_EN
      OP_MUL, OP_DIV:           iclass = CL_MULDIV;
`else
      OP_MUL, OP_DIV:           iclass = CL_NOP;
`endif
      OP_HALT:                  iclass = CL_HALT;
      default:                  iclass = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired mini-SRC control unit. Steps RESET -> T0..T2
// (fetch) -> T3..T7 (per-class execute) and decodes the state into datapath
// controls. Optional mul/div execution is selected by CS_MULDIV_EN in opcode_decode.
import cpu_pkg::*;

module control_sequencer #(
  parameter int OPW   = 5,
  parameter int CTRLW = 4
) (
  input logic Clock,
  input logic Clear,
  control_sequencer_if.master bus
);

  state_t     state;
  iclass_t    iclass;
  logic [OPW-1:0] opcode;
  logic [3:0] op_ctrl;
  logic       paused;
  ctrl_word_t cw_raw, cw;

  assign opcode  = bus.IR[31 -: OPW];
  assign op_ctrl = alu_code(opcode);
  assign paused  = (state == S_T0) && bus.Stop;

  opcode_decode u_decode (.opcode(opcode), .iclass(iclass));

  // One state per clock; the last execute state of each class returns to T0.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= S_RESET;
    else begin
      case (state)
        S_RESET: state <= S_T0;
        S_T0:    if (!bus.Stop) state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= (iclass == CL_NOP)  ? S_T0 :
                          (iclass == CL_HALT) ? S_HALT : S_T3;
        S_T3:    state <= (iclass inside {CL_JR, CL_MFHI, CL_MFLO, CL_IN, CL_OUT}) ? S_T0 : S_T4;
        S_T4:    state <= (iclass inside {CL_UNARY, CL_JAL}) ? S_T0 : S_T5;
        S_T5:    state <= (iclass inside {CL_ALU, CL_IMM, CL_LDI}) ? S_T0 : S_T6;
        S_T6:    state <= (iclass inside {CL_BR, CL_MULDIV}) ? S_T0 : S_T7;
        S_T7:    state <= S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Decode the present state and instruction class into the control word.
  always_comb begin
    cw_raw = '0;
    case (state)
      S_T0: begin cw_raw.PCout = 1'b1; cw_raw.MARin = 1'b1; cw_raw.IncPC = 1'b1; cw_raw.Zlowin = 1'b1; end
      S_T1: begin cw_raw.Zlowout = 1'b1; cw_raw.PCin = 1'b1; cw_raw.Read = 1'b1; cw_raw.MDRin = 1'b1; end
      S_T2: begin cw_raw.MDRout = 1'b1; cw_raw.IRin = 1'b1; end
      S_T3: case (iclass)
        CL_ALU, CL_IMM: begin cw_raw.Grb = 1'b1; cw_raw.Rout = 1'b1; cw_raw.Yin = 1'b1; end
        CL_UNARY: begin cw_raw.Grb = 1'b1; cw_raw.Rout = 1'b1; cw_raw.ctrl = op_ctrl; cw_raw.Zlowin = 1'b1; end
        CL_LD, CL_LDI, CL_ST: begin cw_raw.Grb = 1'b1; cw_raw.BAout = 1'b1; cw_raw.Yin = 1'b1; end
        CL_BR:  begin cw_raw.Gra = 1'b1; cw_raw.Rout = 1'b1; cw_raw.conInput = 1'b1; end
        CL_JR:  begin cw_raw.Gra = 1'b1; cw_raw.Rout = 1'b1; cw_raw.PCin = 1'b1; end
        CL_JAL: begin cw_raw.Grb = 1'b1; cw_raw.Rin = 1'b1; cw_raw.PCout = 1'b1; end
        CL_MFHI: begin cw_raw.HIout = 1'b1; cw_raw.Gra = 1'b1; cw_raw.Rin = 1'b1; end
        CL_MFLO: begin cw_raw.LOout = 1'b1; cw_raw.Gra = 1'b1; cw_raw.Rin = 1'b1; end
        CL_IN:  begin cw_raw.InPortout = 1'b1; cw_raw.Gra = 1'b1; cw_raw.Rin = 1'b1; end
        CL_OUT: begin cw_raw.Gra = 1'b1; cw_raw.Rout = 1'b1; cw_raw.outPortEnable = 1'b1; end
        CL_MULDIV: begin cw_raw.Gra = 1'b1; cw_raw.Rout = 1'b1; cw_raw.Yin = 1'b1; end
        default: ;
      endcase
      S_T4: case (iclass)
        CL_ALU: begin cw_raw.Grc = 1'b1; cw_raw.Rout = 1'b1; cw_raw.ctrl = op_ctrl; cw_raw.Zlowin = 1'b1; end
        CL_IMM: begin cw_raw.Cout = 1'b1; cw_raw.ctrl = op_ctrl; cw_raw.Zlowin = 1'b1; end
        CL_UNARY: begin cw_raw.Zlowout = 1'b1; cw_raw.Gra = 1'b1; cw_raw.Rin = 1'b1; end
        CL_LD, CL_LDI, CL_ST: begin cw_raw.Cout = 1'b1; cw_raw.ctrl = ALU_ADD; cw_raw.Zlowin = 1'b1; end
        CL_BR:  begin cw_raw.PCout = 1'b1; cw_raw.Yin = 1'b1; end
        CL_JAL: begin cw_raw.Gra = 1'b1; cw_raw.Rout = 1'b1; cw_raw.PCin = 1'b1; end
        CL_MULDIV: begin
          cw_raw.Grb = 1'b1; cw_raw.Rout = 1'b1; cw_raw.ctrl = op_ctrl;
          cw_raw.Zlowin = 1'b1; cw_raw.Zhighin = 1'b1;
        end
        default: ;
      endcase
      S_T5: case (iclass)
        CL_ALU, CL_IMM, CL_LDI: begin cw_raw.Zlowout = 1'b1; cw_raw.Gra = 1'b1; cw_raw.Rin = 1'b1; end
        CL_LD, CL_ST: begin cw_raw.Zlowout = 1'b1; cw_raw.MARin = 1'b1; end
        CL_BR: begin cw_raw.Cout = 1'b1; cw_raw.ctrl = ALU_ADD; cw_raw.Zlowin = 1'b1; end
        CL_MULDIV: begin cw_raw.Zlowout = 1'b1; cw_raw.LOin = 1'b1; end
        default: ;
      endcase
      S_T6: case (iclass)
        CL_LD: begin cw_raw.Read = 1'b1; cw_raw.MDRin = 1'b1; end
        CL_ST: begin cw_raw.Gra = 1'b1; cw_raw.Rout = 1'b1; cw_raw.MDRin = 1'b1; end
        CL_BR: begin cw_raw.Zlowout = 1'b1; cw_raw.PCin = bus.CON; end
        CL_MULDIV: begin cw_raw.Zhighout = 1'b1; cw_raw.HIin = 1'b1; end
        default: ;
      endcase
      S_T7: case (iclass)
        CL_LD: begin cw_raw.MDRout = 1'b1; cw_raw.Gra = 1'b1; cw_raw.Rin = 1'b1; end
        CL_ST: cw_raw.wren = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

  // A pause in T0 blanks the fetch strobes so the PC is only incremented once.
  always_comb begin
    cw = cw_raw;
    if (paused) cw = '0;
  end

  assign bus.Run = !(state == S_RESET || state == S_HALT || paused);
  assign bus.ctrl = CTRLW'(cw.ctrl);
  assign bus.PCout = cw.PCout;
  assign bus.Zlowout = cw.Zlowout;
  assign bus.Zhighout = cw.Zhighout;
  assign bus.MDRout = cw.MDRout;
  assign bus.HIout = cw.HIout;
  assign bus.LOout = cw.LOout;
  assign bus.InPortout = cw.InPortout;
  assign bus.Cout = cw.Cout;
  assign bus.MARin = cw.MARin;
  assign bus.MDRin = cw.MDRin;
  assign bus.IRin = cw.IRin;
  assign bus.Yin = cw.Yin;
  assign bus.PCin = cw.PCin;
  assign bus.Zlowin = cw.Zlowin;
  assign bus.Zhighin = cw.Zhighin;
  assign bus.HIin = cw.HIin;
  assign bus.LOin = cw.LOin;
  assign bus.outPortEnable = cw.outPortEnable;
  assign bus.Gra = cw.Gra;
  assign bus.Grb = cw.Grb;
  assign bus.Grc = cw.Grc;
  assign bus.Rin = cw.Rin;
  assign bus.Rout = cw.Rout;
  assign bus.BAout = cw.BAout;
  assign bus.conInput = cw.conInput;
  assign bus.IncPC = cw.IncPC;
  assign bus.Read = cw.Read;
  assign bus.wren = cw.wren;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: walks fetch and several execute
// sequences, reset/abort, Stop pausing and halt, with hand-computed vectors.
// Honors CS_MULDIV_EN for the mul sequence.
import cpu_pkg::*;

module tb_control_sequencer;

  logic Clock, Clear;
  int compared, mismatched;

  control_sequencer_if #(.CTRLW(4)) bus ();

  control_sequencer #(.OPW(5), .CTRLW(4)) dut (.Clock(Clock), .Clear(Clear), .bus(bus));

  localparam logic [27:0] B_PCOUT = 28'd1 << 0,  B_ZLOWOUT = 28'd1 << 1,  B_ZHIGHOUT = 28'd1 << 2;
  localparam logic [27:0] B_MDROUT = 28'd1 << 3, B_HIOUT = 28'd1 << 4,    B_LOOUT = 28'd1 << 5;
  localparam logic [27:0] B_INPORT = 28'd1 << 6, B_COUT = 28'd1 << 7,     B_MARIN = 28'd1 << 8;
  localparam logic [27:0] B_MDRIN = 28'd1 << 9,  B_IRIN = 28'd1 << 10,    B_YIN = 28'd1 << 11;
  localparam logic [27:0] B_PCIN = 28'd1 << 12,  B_ZLOWIN = 28'd1 << 13,  B_ZHIGHIN = 28'd1 << 14;
  localparam logic [27:0] B_HIIN = 28'd1 << 15,  B_LOIN = 28'd1 << 16,    B_OUTPE = 28'd1 << 17;
  localparam logic [27:0] B_GRA = 28'd1 << 18,   B_GRB = 28'd1 << 19,     B_GRC = 28'd1 << 20;
  localparam logic [27:0] B_RIN = 28'd1 << 21,   B_ROUT = 28'd1 << 22,    B_BAOUT = 28'd1 << 23;
  localparam logic [27:0] B_CONIN = 28'd1 << 24, B_INCPC = 28'd1 << 25,   B_READ = 28'd1 << 26;
  localparam logic [27:0] B_WREN = 28'd1 << 27;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Packs the observed DUT outputs as {Run, ctrl, control bits}.
  function automatic logic [63:0] snap();
    logic [27:0] b;
    b = '0;
    b[0] = bus.PCout;   b[1] = bus.Zlowout;  b[2] = bus.Zhighout; b[3] = bus.MDRout;
    b[4] = bus.HIout;   b[5] = bus.LOout;    b[6] = bus.InPortout; b[7] = bus.Cout;
    b[8] = bus.MARin;   b[9] = bus.MDRin;    b[10] = bus.IRin;    b[11] = bus.Yin;
    b[12] = bus.PCin;   b[13] = bus.Zlowin;  b[14] = bus.Zhighin; b[15] = bus.HIin;
    b[16] = bus.LOin;   b[17] = bus.outPortEnable; b[18] = bus.Gra; b[19] = bus.Grb;
    b[20] = bus.Grc;    b[21] = bus.Rin;     b[22] = bus.Rout;    b[23] = bus.BAout;
    b[24] = bus.conInput; b[25] = bus.IncPC; b[26] = bus.Read;    b[27] = bus.wren;
    return {31'b0, bus.Run, bus.ctrl, b};
  endfunction

  function automatic logic [63:0] ev(logic [27:0] b, logic [3:0] c, logic r);
    return {31'b0, r, c, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Checks the current cycle (plus bus-drive exclusivity), then advances one clock.
  task automatic applyStimulus(input string tag, input logic [63:0] expected);
    logic [63:0] s;
    s = snap();
    checkOutput(tag, s, expected);
    checkOutput({tag, "_busOne"}, 64'($countones(s[7:0]) <= 1), 64'd1);
    @(posedge Clock);
    #1;
  endtask

  task automatic doFetch();
    applyStimulus("T0", ev(B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN, ALU_NONE, 1'b1));
    applyStimulus("T1", ev(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN, ALU_NONE, 1'b1));
    applyStimulus("T2", ev(B_MDROUT | B_IRIN, ALU_NONE, 1'b1));
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    bus.IR = 32'h1A920000;
    bus.CON = 1'b0;
    bus.Stop = 1'b0;
    Clear = 1'b1;
    #1 Clear = 1'b0;
    #11;
    checkOutput("reset", snap(), 64'd0);
    @(posedge Clock); #1;
    Clear = 1'b1;
    @(posedge Clock); #1;

    // add R5,R2,R4
    doFetch();
    applyStimulus("addT3", ev(B_GRB | B_ROUT | B_YIN, ALU_NONE, 1'b1));
    applyStimulus("addT4", ev(B_GRC | B_ROUT | B_ZLOWIN, ALU_ADD, 1'b1));
    applyStimulus("addT5", ev(B_ZLOWOUT | B_GRA | B_RIN, ALU_NONE, 1'b1));

    // second add, aborted by Clear in T4
    doFetch();
    applyStimulus("add2T3", ev(B_GRB | B_ROUT | B_YIN, ALU_NONE, 1'b1));
    checkOutput("add2T4", snap(), ev(B_GRC | B_ROUT | B_ZLOWIN, ALU_ADD, 1'b1));
    Clear = 1'b0;
    #1;
    checkOutput("abort", snap(), 64'd0);
    @(posedge Clock); #1;
    checkOutput("abortHold", snap(), 64'd0);
    Clear = 1'b1;
    @(posedge Clock); #1;

    // jal R6
    bus.IR = 32'hAB000000;
    doFetch();
    applyStimulus("jalT3", ev(B_GRB | B_RIN | B_PCOUT, ALU_NONE, 1'b1));
    applyStimulus("jalT4", ev(B_GRA | B_ROUT | B_PCIN, ALU_NONE, 1'b1));

    // Stop in T0 pauses with everything low
    bus.Stop = 1'b1;
    #1;
    checkOutput("stopHold", snap(), 64'd0);
    @(posedge Clock); #1;
    checkOutput("stopHold2", snap(), 64'd0);
    bus.Stop = 1'b0;
    #1;
    checkOutput("stopRelease", snap(), ev(B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN, ALU_NONE, 1'b1));

    // br with CON=0; Stop raised mid-instruction is ignored
    bus.IR = 32'h98000000;
    bus.CON = 1'b0;
    applyStimulus("brT0", ev(B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN, ALU_NONE, 1'b1));
    bus.Stop = 1'b1;
    applyStimulus("brT1", ev(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN, ALU_NONE, 1'b1));
    applyStimulus("brT2", ev(B_MDROUT | B_IRIN, ALU_NONE, 1'b1));
    applyStimulus("brT3", ev(B_GRA | B_ROUT | B_CONIN, ALU_NONE, 1'b1));
    applyStimulus("brT4", ev(B_PCOUT | B_YIN, ALU_NONE, 1'b1));
    applyStimulus("brT5", ev(B_COUT | B_ZLOWIN, ALU_ADD, 1'b1));
    bus.Stop = 1'b0;
    applyStimulus("brT6con0", ev(B_ZLOWOUT, ALU_NONE, 1'b1));

    // br with CON=1
    bus.CON = 1'b1;
    doFetch();
    applyStimulus("br1T3", ev(B_GRA | B_ROUT | B_CONIN, ALU_NONE, 1'b1));
    applyStimulus("br1T4", ev(B_PCOUT | B_YIN, ALU_NONE, 1'b1));
    applyStimulus("br1T5", ev(B_COUT | B_ZLOWIN, ALU_ADD, 1'b1));
    applyStimulus("brT6con1", ev(B_ZLOWOUT | B_PCIN, ALU_NONE, 1'b1));
    bus.CON = 1'b0;

    // ld R1,16(R0)
    bus.IR = 32'h00800010;
    doFetch();
    applyStimulus("ldT3", ev(B_GRB | B_BAOUT | B_YIN, ALU_NONE, 1'b1));
    applyStimulus("ldT4", ev(B_COUT | B_ZLOWIN, ALU_ADD, 1'b1));
    applyStimulus("ldT5", ev(B_ZLOWOUT | B_MARIN, ALU_NONE, 1'b1));
    applyStimulus("ldT6", ev(B_READ | B_MDRIN, ALU_NONE, 1'b1));
    applyStimulus("ldT7", ev(B_MDROUT | B_GRA | B_RIN, ALU_NONE, 1'b1));

    // neg
    bus.IR = 32'h88000000;
    doFetch();
    applyStimulus("negT3", ev(B_GRB | B_ROUT | B_ZLOWIN, ALU_NEG, 1'b1));
    applyStimulus("negT4", ev(B_ZLOWOUT | B_GRA | B_RIN, ALU_NONE, 1'b1));

    // reserved opcode 11111 behaves as nop
    bus.IR = 32'hF8000000;
    doFetch();

    // mul
    bus.IR = 32'h80000000;
    doFetch();
`ifdef CS_MULDIV_EN
    applyStimulus("mulT3", ev(B_GRA | B_ROUT | B_YIN, ALU_NONE, 1'b1));
    applyStimulus("mulT4", ev(B_GRB | B_ROUT | B_ZLOWIN | B_ZHIGHIN, ALU_MUL, 1'b1));
    applyStimulus("mulT5", ev(B_ZLOWOUT | B_LOIN, ALU_NONE, 1'b1));
    applyStimulus("mulT6", ev(B_ZHIGHOUT | B_HIIN, ALU_NONE, 1'b1));
`endif

    // halt: terminal, Stop toggling has no effect
    bus.IR = 32'hD8000000;
    doFetch();
    for (int i = 0; i < 20; i++) begin
      bus.Stop = i[0];
      applyStimulus("halt", 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the single-bus mini-SRC datapath. It sits directly upstream of `datapath` and drives that block's control inputs each clock. It steps through fetch (T0–T2) and per-opcode execute states (T3–T7), which replaces bench-driven control-signal sequencing. It consumes the IR opcode and the CON flip-flop result from the datapath.

## Interface
Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- CTRLW, 4, ALU operation select width (`ctrl`).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Clear  in  1  reset, asynchronous, active-low.
- IR  in  32  instruction register contents from the datapath.
- CON  in  1  branch-condition flip-flop output.
- Stop  in  1  external pause; sampled only in T0.
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout  out  1 each  bus-drive enables.
- MARin, MDRin, IRin, Yin, PCin, Zlowin, Zhighin, HIin, LOin, outPortEnable  out  1 each  register load enables.
- Gra, Grb, Grc, Rin, Rout, BAout, conInput  out  1 each  register-select and CON-load controls.
- IncPC, Read, wren  out  1 each  PC-increment, memory read and memory write strobes.
- ctrl  out  CTRLW  ALU operation select.
- Run  out  1  high while the sequencer is executing; low after halt or while paused.

## Operation
- States: RESET, T0–T7, HALT. Outputs are a pure decode of the present state plus IR[31:27]. No output is registered separately.
- Fetch:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute by opcode:
  - R-type ALU (add, sub, and, or, shl, shr, shra, rol, ror):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, ctrl=op, Zlowin.
    - T5: Zlowout, Gra, Rin.
  - Unary (neg, not): T3 Grb, Rout, ctrl=op, Zlowin; T4 Zlowout, Gra, Rin.
  - Immediate (addi, andi, ori): same as R-type, with T4 driving Cout in place of Grc/Rout.
  - ld / ldi / st: address is Rb+C (BAout, so R0 reads as 0).
    - ld: T5 MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin.
    - ldi: T5 writes Z directly to Ra.
    - st: T6 Gra, Rout, MDRin; T7 wren.
  - br: T3 Gra, Rout, conInput; T4 PCout, Yin; T5 Cout, ctrl=ADD, Zlowin; T6 Zlowout, PCin only when CON=1.
  - jr: T3 Gra, Rout, PCin.
  - jal: T3 Grb, Rin, PCout (link); T4 Gra, Rout, PCin.
  - mfhi / mflo: T3 HIout or LOout, Gra, Rin.
  - in: T3 InPortout, Gra, Rin.
  - out: T3 Gra, Rout, outPortEnable.
  - mul / div: T3 Gra, Rout, Yin; T4 Grb, Rout, ctrl=op, Zlowin, Zhighin; T5 Zlowout, LOin; T6 Zhighout, HIin.
  - nop: returns to T0 after T2.
  - halt: enters HALT after T2.
- The last execute state of each opcode transitions to T0.
- HALT is terminal. Only Clear leaves it. Run=0 in HALT.
- Undefined opcodes (11100–11111) behave as nop.
- ctrl codes (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV) are fixed in the shared package.

## Timing
- Clear=0 asynchronously forces RESET: every output is 0 except ctrl=0 and Run=0.
- First rising edge after Clear deasserts: RESET→T0, and Run=1 from then on.
- Exactly one state per clock. Each output is asserted for the full cycle of its state.
- Latency:
  - Fetch: 3 cycles.
  - Execute: jr/jal/mf/in/out 1–2 cycles; ALU 2–3; ld/st 5; br 4; mul/div 4.
- Stop=1 sampled in T0 holds the FSM in T0 with all outputs 0 and Run=0. The PC is not incremented twice. Fetch resumes on the first cycle Stop=0.
- Stop is ignored outside T0, so an instruction in progress always completes.
- Clear asserted mid-instruction abandons it immediately. There is no partial writeback on later edges.
- CON is sampled only in br T6. It must be stable by that rising edge (conInput loaded it in T3).
- Never more than one bus-drive output is high in any state. Verification asserts this.

## Configuration
- CS_MULDIV_EN defined: mul/div execute states T3–T6 are as above.
- CS_MULDIV_EN undefined: mul and div opcodes decode as nop. HIin, LOin and Zhighin stay 0 in all states, and the T6 state is reachable only via ld/st/br.

## Structure
- Package `cpu_pkg`: opcode localparams (ld=00000 … halt=11011), ctrl ALU codes, and the state enum typedef.
- One sub-module is natural: `opcode_decode`, a combinational IR[31:27]→instruction-class decoder (ALU, UNARY, IMM, LD, LDI, ST, BR, JR, JAL, MFHI, MFLO, IN, OUT, MULDIV, NOP, HALT).
- The sequencer FSM plus output decode lives in `control_sequencer`.

## Test plan
- Reset:
  - Clear=0 mid-T4 of add → all outputs 0 within the same cycle.
  - Release → T0 next edge with PCout=MARin=IncPC=Zlowin=1.
- add R5,R2,R4 (IR=32'h1A920000):
  - T3 Grb/Rout/Yin, T4 Grc/Rout/ctrl=ADD/Zlowin, T5 Zlowout/Gra/Rin.
  - Then T0; 6 cycles total.
- jal R6 (IR=32'hAB000000): T3 Grb, Rin, PCout; T4 Gra, Rout, PCin; then T0.
- br with CON=0 → PCin stays 0 in T6. With CON=1 → PCin=1 in T6 only.
- halt (IR=32'hD8000000) → HALT after T2, Run=0, outputs 0 for 20 cycles; Stop toggling has no effect.
- mul (IR opcode 10000) with CS_MULDIV_EN → LOin in T5, HIin in T6. Without the macro → T2→T0 and HIin never high.
